// File: rtl/a2d_sched.sv
// ---------------------------------------------------------------------------
// a2d_sched -- A2D conversion scheduler
//
// Owns the single A2D SPI master and converts four channels in round-robin
// order (rr 0/1/2/3 -> ADC channel 0/4/5/6 -> lft_ld/rght_ld/steer_pot/batt).
// Each conversion is two SPI transactions with the same command word: the
// first selects the channel, the second returns the result.
//
// Parameters:
//   TMO_CYC   cycles to wait for spi_done in WAIT1/WAIT2 before aborting
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   nxt        one-cycle request to start a conversion
//   spi_done   one-cycle pulse, SPI transaction complete
//   spi_rd     SPI read data, valid with spi_done
//   spi_wrt    one-cycle pulse, start SPI transaction
//   spi_cmd    SPI command word, stable from spi_wrt until spi_done
//   lft_ld, rght_ld, steer_pot, batt   latest converted results
//   vld        one-cycle pulse, a result register was updated
//   tmo_err    sticky SPI timeout flag (cleared by reset only)
//
// Build option:
//   A2D_SWEEP_EN  each nxt converts all four channels back-to-back from rr=0,
//                 with a single vld after batt is captured.
// ---------------------------------------------------------------------------
module a2d_sched #(
    parameter int TMO_CYC = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        nxt,
    input  logic        spi_done,
    input  logic [15:0] spi_rd,
    output logic        spi_wrt,
    output logic [15:0] spi_cmd,
    output logic [11:0] lft_ld,
    output logic [11:0] rght_ld,
    output logic [11:0] steer_pot,
    output logic [11:0] batt,
    output logic        vld,
    output logic        tmo_err
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] CMD   = 3'd1;
    localparam logic [2:0] WAIT1 = 3'd2;
    localparam logic [2:0] GAP   = 3'd3;
    localparam logic [2:0] READ  = 3'd4;
    localparam logic [2:0] WAIT2 = 3'd5;

    localparam int            TW       = $clog2(TMO_CYC + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYC - 1);

    logic [2:0]    state;
    logic [1:0]    rr;
    logic [1:0]    rr_inc;
    logic [1:0]    rr_start;
    logic          pend;
    logic [TW-1:0] tmo_cnt;
    logic          tmo_hit;
    logic          unused_rd_hi;

    function automatic logic [15:0] cmd_of(input logic [1:0] r);
        logic [2:0] ch;
        case (r)
            2'd0:    ch = 3'd0;
            2'd1:    ch = 3'd4;
            2'd2:    ch = 3'd5;
            default: ch = 3'd6;
        endcase
        return {2'b00, ch, 11'h000};
    endfunction

    assign rr_inc       = rr + 2'd1;
    assign unused_rd_hi = ^spi_rd[15:12];
    // Timeout fires on the TMO_CYC-th waiting cycle unless spi_done arrives.
    assign tmo_hit      = (tmo_cnt == TMO_LAST) && !spi_done;

`ifdef A2D_SWEEP_EN
    assign rr_start = 2'd0;
`else
    assign rr_start = rr;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rr        <= '0;
            pend      <= 1'b0;
            tmo_cnt   <= '0;
            spi_wrt   <= 1'b0;
            spi_cmd   <= '0;
            lft_ld    <= '0;
            rght_ld   <= '0;
            steer_pot <= '0;
            batt      <= '0;
            vld       <= 1'b0;
            tmo_err   <= 1'b0;
        end else begin
            spi_wrt <= 1'b0;
            vld     <= 1'b0;
            // One-deep request buffer; extra requests while pending are lost.
            if (nxt && state != IDLE)
                pend <= 1'b1;

            case (state)
                IDLE: begin
                    if (nxt || pend) begin
                        pend    <= 1'b0;
                        rr      <= rr_start;
                        spi_cmd <= cmd_of(rr_start);
                        spi_wrt <= 1'b1;
                        tmo_cnt <= '0;
                        state   <= CMD;
                    end
                end
                CMD: state <= WAIT1;
                WAIT1: begin
                    if (spi_done) begin
                        state <= GAP;
                    end else if (tmo_hit) begin
                        tmo_err <= 1'b1;
                        rr      <= rr_inc;
                        state   <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                GAP: begin
                    spi_wrt <= 1'b1;
                    tmo_cnt <= '0;
                    state   <= READ;
                end
                READ: state <= WAIT2;
                WAIT2: begin
                    if (spi_done) begin
                        case (rr)
                            2'd0:    lft_ld    <= spi_rd[11:0];
                            2'd1:    rght_ld   <= spi_rd[11:0];
                            2'd2:    steer_pot <= spi_rd[11:0];
                            default: batt      <= spi_rd[11:0];
                        endcase
                        rr <= rr_inc;
`ifdef A2D_SWEEP_EN
                        // Mid-sweep: chain straight into the next channel.
                        if (rr != 2'd3) begin
                            spi_cmd <= cmd_of(rr_inc);
                            spi_wrt <= 1'b1;
                            tmo_cnt <= '0;
                            state   <= CMD;
                        end else begin
                            vld   <= 1'b1;
                            state <= IDLE;
                        end
`else
                        vld   <= 1'b1;
                        state <= IDLE;
`endif
                    end else if (tmo_hit) begin
                        tmo_err <= 1'b1;
                        rr      <= rr_inc;
                        state   <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_a2d_sched.sv
module tb_a2d_sched;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        nxt = 1'b0;
    logic        spi_done = 1'b0;
    logic [15:0] spi_rd = '0;
    logic        spi_wrt;
    logic [15:0] spi_cmd;
    logic [11:0] lft_ld, rght_ld, steer_pot, batt;
    logic        vld;
    logic        tmo_err;

    always #5 clk = ~clk;

    a2d_sched #(.TMO_CYC(TMO)) dut (
        .clk(clk), .rst(rst), .nxt(nxt), .spi_done(spi_done), .spi_rd(spi_rd),
        .spi_wrt(spi_wrt), .spi_cmd(spi_cmd), .lft_ld(lft_ld), .rght_ld(rght_ld),
        .steer_pot(steer_pot), .batt(batt), .vld(vld), .tmo_err(tmo_err)
    );

    logic [11:0] dut_reg [4];
    assign dut_reg[0] = lft_ld;
    assign dut_reg[1] = rght_ld;
    assign dut_reg[2] = steer_pot;
    assign dut_reg[3] = batt;

    int n_chk = 0;
    int n_fail = 0;

    // Reference model: expected result registers, pointer and sticky flag.
    logic [11:0] exp_reg [4];
    int          exp_rr;
    logic        exp_tmo;
    int unsigned CH [4] = '{0, 4, 5, 6};

    function automatic logic [15:0] exp_cmd(input int idx);
        logic [2:0] c;
        c = 3'(CH[idx]);
        return {2'b00, c, 11'h000};
    endfunction

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: logs command words, spi_wrt cycles and vld cycles.
    logic [15:0] wrt_cmd [$];
    int unsigned wrt_cyc [$];
    int unsigned vld_cyc [$];
    always @(posedge clk) begin
        #1;
        if (!rst) begin
            if (spi_wrt) begin
                wrt_cmd.push_back(spi_cmd);
                wrt_cyc.push_back(cyc);
            end
            if (vld) vld_cyc.push_back(cyc);
        end
    end

    // SPI slave model. Test controls (written only by tests):
    bit          resp_en = 1'b1;
    int unsigned resp_dly = 0;      // 0 = random 1..4 cycles
    bit          use_fixed = 1'b0;
    logic [11:0] fixed_val = '0;
    int unsigned stray_req = 0;
    // Responder-owned state and logs:
    bit          busy = 1'b0;
    bit          phase = 1'b0;
    int unsigned cnt = 0;
    int unsigned stray_ack = 0;
    logic [11:0] rv;
    logic [11:0] rd_log [$];
    int unsigned done_log [$];

    always @(negedge clk) begin
        spi_done = 1'b0;
        if (rst) begin
            busy  = 1'b0;
            phase = 1'b0;
        end else if (busy) begin
            if (cnt == 0) begin
                spi_done = 1'b1;
                busy     = 1'b0;
                if (phase) begin
                    rv     = use_fixed ? fixed_val : 12'($urandom);
                    spi_rd = {4'($urandom), rv};
                    rd_log.push_back(rv);
                    done_log.push_back(cyc + 1);
                end else begin
                    spi_rd = 16'($urandom);
                end
                phase = !phase;
            end else begin
                cnt = cnt - 1;
            end
        end else if (stray_req != stray_ack) begin
            spi_done  = 1'b1;
            spi_rd    = 16'($urandom);
            stray_ack = stray_ack + 1;
        end
        if (!rst && resp_en && spi_wrt) begin
            busy = 1'b1;
            cnt  = (resp_dly == 0) ? $urandom_range(3, 0) : resp_dly - 1;
        end
    end

    task automatic pulse_nxt(output int unsigned t);
        @(negedge clk);
        nxt = 1'b1;
        t   = cyc + 1;
        @(negedge clk);
        nxt = 1'b0;
    endtask

    task automatic wait_vld(input int n, output bit ok);
        int k = 0;
        while (vld_cyc.size() < n && k < 400) begin
            @(negedge clk);
            k++;
        end
        ok = (vld_cyc.size() >= n);
    endtask

    task automatic wait_wrt(input int n, output bit ok);
        int k = 0;
        while (wrt_cyc.size() < n && k < 400) begin
            @(negedge clk);
            k++;
        end
        ok = (wrt_cyc.size() >= n);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) exp_reg[i] = '0;
        exp_rr  = 0;
        exp_tmo = 1'b0;
    endtask

    task automatic test_reset();
        int bw;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
        bw = wrt_cyc.size();
        repeat (100) @(negedge clk);
        n_chk++; if (wrt_cyc.size() !== bw) begin n_fail++; $display("FAIL reset_no_wrt: got %0d pulses expected 0", wrt_cyc.size() - bw); end
        n_chk++; if (spi_wrt !== 1'b0) begin n_fail++; $display("FAIL reset_spi_wrt: got %b expected 0", spi_wrt); end
        n_chk++; if (spi_cmd !== 16'h0) begin n_fail++; $display("FAIL reset_spi_cmd: got %h expected 0000", spi_cmd); end
        n_chk++; if (vld !== 1'b0) begin n_fail++; $display("FAIL reset_vld: got %b expected 0", vld); end
        n_chk++; if (tmo_err !== 1'b0) begin n_fail++; $display("FAIL reset_tmo_err: got %b expected 0", tmo_err); end
        for (int i = 0; i < 4; i++) begin
            n_chk++; if (dut_reg[i] !== 12'h0) begin n_fail++; $display("FAIL reset_reg%0d: got %h expected 000", i, dut_reg[i]); end
        end
    endtask

    task automatic test_stray_done();
        int bw, bv;
        bw = wrt_cyc.size(); bv = vld_cyc.size();
        stray_req = stray_req + 1;
        repeat (6) @(negedge clk);
        n_chk++; if (vld_cyc.size() !== bv) begin n_fail++; $display("FAIL stray_vld: got %0d expected 0", vld_cyc.size() - bv); end
        n_chk++; if (wrt_cyc.size() !== bw) begin n_fail++; $display("FAIL stray_wrt: got %0d expected 0", wrt_cyc.size() - bw); end
        for (int i = 0; i < 4; i++) begin
            n_chk++; if (dut_reg[i] !== exp_reg[i]) begin n_fail++; $display("FAIL stray_reg%0d: got %h expected %h", i, dut_reg[i], exp_reg[i]); end
        end
    endtask

`ifndef A2D_SWEEP_EN
    // One conversion per nxt; fixed values or random ones from the SPI model.
    task automatic test_convert(input bit fixed, input logic [11:0] val, input string tag);
        int bw, bv, br;
        int unsigned t;
        bit ok;
        use_fixed = fixed; fixed_val = val; resp_dly = 0;
        bw = wrt_cyc.size(); bv = vld_cyc.size(); br = rd_log.size();
        pulse_nxt(t);
        wait_vld(bv + 1, ok);
        n_chk++; if (!ok) begin n_fail++; $display("FAIL %s_vld_timeout: got no vld expected vld", tag); end
        repeat (3) @(negedge clk);
        if (ok && wrt_cyc.size() >= bw + 2 && rd_log.size() > br) begin
            n_chk++; if (wrt_cyc[bw] !== t) begin n_fail++; $display("FAIL %s_start_latency: got cyc %0d expected %0d", tag, wrt_cyc[bw], t); end
            n_chk++; if (wrt_cmd[bw] !== exp_cmd(exp_rr)) begin n_fail++; $display("FAIL %s_cmd1: got %h expected %h", tag, wrt_cmd[bw], exp_cmd(exp_rr)); end
            n_chk++; if (wrt_cmd[bw+1] !== exp_cmd(exp_rr)) begin n_fail++; $display("FAIL %s_cmd2: got %h expected %h", tag, wrt_cmd[bw+1], exp_cmd(exp_rr)); end
            n_chk++; if (vld_cyc[bv] !== done_log[br]) begin n_fail++; $display("FAIL %s_vld_latency: got cyc %0d expected %0d", tag, vld_cyc[bv], done_log[br]); end
            exp_reg[exp_rr] = rd_log[br];
            exp_rr = (exp_rr + 1) % 4;
        end
        n_chk++; if (wrt_cyc.size() - bw !== 2) begin n_fail++; $display("FAIL %s_wrt_count: got %0d expected 2", tag, wrt_cyc.size() - bw); end
        n_chk++; if (vld_cyc.size() - bv !== 1) begin n_fail++; $display("FAIL %s_vld_count: got %0d expected 1", tag, vld_cyc.size() - bv); end
        for (int i = 0; i < 4; i++) begin
            n_chk++; if (dut_reg[i] !== exp_reg[i]) begin n_fail++; $display("FAIL %s_reg%0d: got %h expected %h", tag, i, dut_reg[i], exp_reg[i]); end
        end
        n_chk++; if (tmo_err !== exp_tmo) begin n_fail++; $display("FAIL %s_tmo_err: got %b expected %b", tag, tmo_err, exp_tmo); end
    endtask

    task automatic test_round_robin();
        logic [11:0] vals [4] = '{12'h350, 12'h340, 12'h800, 12'hC00};
        for (int i = 0; i < 4; i++) test_convert(1'b1, vals[i], "rr");
        // Pointer wrapped: the next conversion must land on channel 0 again.
        test_convert(1'b1, 12'h5A5, "rr_wrap");
    endtask

    task automatic test_random();
        for (int i = 0; i < 12; i++) begin
            repeat ($urandom_range(3, 0)) @(negedge clk);
            test_convert(1'b0, '0, "rand");
        end
    endtask

    // Several nxt during WAIT1 collapse into a single pending conversion.
    task automatic test_pend(input int unsigned dly, input bit at_wait2, input string tag);
        int bw, bv, br;
        int unsigned t;
        bit ok;
        use_fixed = 1'b0; resp_dly = dly;
        bw = wrt_cyc.size(); bv = vld_cyc.size(); br = rd_log.size();
        pulse_nxt(t);
        if (at_wait2) begin
            wait_wrt(bw + 2, ok);
            repeat (dly - 1) @(negedge clk);
            pulse_nxt(t);
        end else begin
            wait_wrt(bw + 1, ok);
            for (int i = 0; i < 3; i++) pulse_nxt(t);
        end
        n_chk++; if (!ok) begin n_fail++; $display("FAIL %s_wrt_timeout: got no spi_wrt expected spi_wrt", tag); end
        wait_vld(bv + 2, ok);
        repeat (40) @(negedge clk);
        n_chk++; if (vld_cyc.size() - bv !== 2) begin n_fail++; $display("FAIL %s_vld_count: got %0d expected 2", tag, vld_cyc.size() - bv); end
        n_chk++; if (wrt_cyc.size() - bw !== 4) begin n_fail++; $display("FAIL %s_wrt_count: got %0d expected 4", tag, wrt_cyc.size() - bw); end
        if (vld_cyc.size() >= bv + 2 && wrt_cyc.size() >= bw + 4 && rd_log.size() >= br + 2) begin
            n_chk++; if (wrt_cyc[bw+2] !== vld_cyc[bv] + 1) begin n_fail++; $display("FAIL %s_restart: got cyc %0d expected %0d", tag, wrt_cyc[bw+2], vld_cyc[bv] + 1); end
            exp_reg[exp_rr] = rd_log[br];
            exp_rr = (exp_rr + 1) % 4;
            n_chk++; if (wrt_cmd[bw+2] !== exp_cmd(exp_rr)) begin n_fail++; $display("FAIL %s_cmd: got %h expected %h", tag, wrt_cmd[bw+2], exp_cmd(exp_rr)); end
            exp_reg[exp_rr] = rd_log[br+1];
            exp_rr = (exp_rr + 1) % 4;
        end
        for (int i = 0; i < 4; i++) begin
            n_chk++; if (dut_reg[i] !== exp_reg[i]) begin n_fail++; $display("FAIL %s_reg%0d: got %h expected %h", tag, i, dut_reg[i], exp_reg[i]); end
        end
        resp_dly = 0;
    endtask

    task automatic test_timeout();
        int bw, bv;
        int unsigned t;
        resp_en = 1'b0;
        bw = wrt_cyc.size(); bv = vld_cyc.size();
        pulse_nxt(t);
        while (cyc < t + TMO) @(negedge clk);
        n_chk++; if (tmo_err !== 1'b0) begin n_fail++; $display("FAIL tmo_early: got %b expected 0", tmo_err); end
        @(negedge clk);
        n_chk++; if (tmo_err !== 1'b1) begin n_fail++; $display("FAIL tmo_set: got %b expected 1", tmo_err); end
        repeat (10) @(negedge clk);
        n_chk++; if (vld_cyc.size() !== bv) begin n_fail++; $display("FAIL tmo_no_vld: got %0d expected 0", vld_cyc.size() - bv); end
        n_chk++; if (wrt_cyc.size() - bw !== 1) begin n_fail++; $display("FAIL tmo_wrt_count: got %0d expected 1", wrt_cyc.size() - bw); end
        exp_tmo = 1'b1;
        exp_rr = (exp_rr + 1) % 4;
        resp_en = 1'b1;
        test_convert(1'b0, '0, "post_tmo");
    endtask
`else
    task automatic test_sweep();
        int bw, bv, br;
        int unsigned t;
        bit ok;
        use_fixed = 1'b0; resp_dly = 0;
        bw = wrt_cyc.size(); bv = vld_cyc.size(); br = rd_log.size();
        pulse_nxt(t);
        wait_vld(bv + 1, ok);
        n_chk++; if (!ok) begin n_fail++; $display("FAIL sweep_vld_timeout: got no vld expected vld"); end
        repeat (30) @(negedge clk);
        n_chk++; if (wrt_cyc.size() - bw !== 8) begin n_fail++; $display("FAIL sweep_wrt_count: got %0d expected 8", wrt_cyc.size() - bw); end
        n_chk++; if (vld_cyc.size() - bv !== 1) begin n_fail++; $display("FAIL sweep_vld_count: got %0d expected 1", vld_cyc.size() - bv); end
        if (wrt_cyc.size() >= bw + 8 && rd_log.size() >= br + 4 && ok) begin
            n_chk++; if (wrt_cyc[bw] !== t) begin n_fail++; $display("FAIL sweep_latency: got cyc %0d expected %0d", wrt_cyc[bw], t); end
            for (int i = 0; i < 8; i++) begin
                n_chk++; if (wrt_cmd[bw+i] !== exp_cmd(i / 2)) begin n_fail++; $display("FAIL sweep_cmd%0d: got %h expected %h", i, wrt_cmd[bw+i], exp_cmd(i / 2)); end
            end
            n_chk++; if (vld_cyc[bv] !== done_log[br+3]) begin n_fail++; $display("FAIL sweep_vld_latency: got cyc %0d expected %0d", vld_cyc[bv], done_log[br+3]); end
            for (int i = 0; i < 4; i++) exp_reg[i] = rd_log[br+i];
        end
        for (int i = 0; i < 4; i++) begin
            n_chk++; if (dut_reg[i] !== exp_reg[i]) begin n_fail++; $display("FAIL sweep_reg%0d: got %h expected %h", i, dut_reg[i], exp_reg[i]); end
        end
    endtask
`endif

    task automatic test_reset_mid();
        int bw, bv;
        int unsigned t;
        bit ok;
        use_fixed = 1'b0; resp_dly = 8;
        bw = wrt_cyc.size(); bv = vld_cyc.size();
        pulse_nxt(t);
        wait_wrt(bw + 2, ok);
        n_chk++; if (!ok) begin n_fail++; $display("FAIL rstmid_wrt_timeout: got no read spi_wrt expected one"); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_reset();
        n_chk++; if (spi_cmd !== 16'h0) begin n_fail++; $display("FAIL rstmid_spi_cmd: got %h expected 0000", spi_cmd); end
        n_chk++; if (tmo_err !== 1'b0) begin n_fail++; $display("FAIL rstmid_tmo_err: got %b expected 0", tmo_err); end
        for (int i = 0; i < 4; i++) begin
            n_chk++; if (dut_reg[i] !== 12'h0) begin n_fail++; $display("FAIL rstmid_reg%0d: got %h expected 000", i, dut_reg[i]); end
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        bw = wrt_cyc.size(); bv = vld_cyc.size();
        repeat (30) @(negedge clk);
        n_chk++; if (vld_cyc.size() !== bv) begin n_fail++; $display("FAIL rstmid_no_vld: got %0d expected 0", vld_cyc.size() - bv); end
        n_chk++; if (wrt_cyc.size() !== bw) begin n_fail++; $display("FAIL rstmid_no_wrt: got %0d expected 0", wrt_cyc.size() - bw); end
        resp_dly = 0;
    endtask

    initial begin
        test_reset();
        test_stray_done();
`ifndef A2D_SWEEP_EN
        test_round_robin();
        test_random();
        test_pend(6, 1'b0, "pend");
        test_pend(3, 1'b1, "pend_wait2");
        test_timeout();
        test_reset_mid();
        test_convert(1'b0, '0, "post_rst");
`else
        test_sweep();
        test_reset_mid();
        test_sweep();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
